// File: rtl/align_accum_serial_pkg.sv
// Shared MAC-subsystem constants and the FSM state encoding used by the
// serial align/accumulate stage.
package align_accum_serial_pkg;

  localparam int NUM_LANES  = 9;
  localparam int FP16_EXP_W = 5;

  localparam int EXP_W_DEF  = FP16_EXP_W + 1;
  localparam int MANT_W_DEF = 12;
  localparam int GUARD_DEF  = 3;
  localparam int ACC_W_DEF  = MANT_W_DEF + GUARD_DEF + 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/align_shift_lane.sv
// Aligns one lane's significand to the shared maximum exponent and applies
// its sign; flags lanes whose exponent exceeds the maximum.
module align_shift_lane
  import align_accum_serial_pkg::*;
#(
  parameter int EXP_W  = EXP_W_DEF,
  parameter int MANT_W = MANT_W_DEF,
  parameter int GUARD  = GUARD_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic [MANT_W-1:0]       mant_i,
  input  logic [EXP_W-1:0]        exp_i,
  input  logic [EXP_W-1:0]        max_exp_i,
  input  logic                    skip_i,
  input  logic                    sign_i,
  output logic signed [ACC_W-1:0] aligned_o,
  output logic                    over_o
);

  localparam int SH_W = MANT_W + GUARD;
  localparam logic [EXP_W-1:0] SH_LIM = EXP_W'(SH_W);

  logic              exp_over;
  logic [EXP_W-1:0]  shamt;
  logic [SH_W-1:0]   ext;
  logic [SH_W-1:0]   shifted;
  logic [ACC_W-1:0]  mag;

  always_comb begin
    exp_over = (exp_i > max_exp_i);
    // An out-of-range exponent is treated as already aligned (no shift).
    shamt    = exp_over ? '0 : (max_exp_i - exp_i);
    ext      = {mant_i, {GUARD{1'b0}}};
    shifted  = (shamt >= SH_LIM) ? '0 : (ext >> shamt);
    mag      = {{(ACC_W-SH_W){1'b0}}, shifted};
    if (skip_i) begin
      aligned_o = '0;
    end else if (sign_i) begin
      aligned_o = -mag;
    end else begin
      aligned_o = mag;
    end
    over_o = exp_over & ~skip_i;
  end

endmodule

// File: rtl/align_accum_serial.sv
// Serial aligner/accumulator: captures a 9-lane bundle, sums one aligned lane
// per cycle, and holds the signed result until the normaliser takes it.
module align_accum_serial
  import align_accum_serial_pkg::*;
#(
  parameter int EXP_W  = EXP_W_DEF,
  parameter int MANT_W = MANT_W_DEF,
  parameter int GUARD  = GUARD_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [NUM_LANES-1:0]          i_skip,
  input  logic [EXP_W-1:0]              i_max_exp,
  input  logic [NUM_LANES-1:0]          i_sign,
  input  logic [NUM_LANES*EXP_W-1:0]    i_exp,
  input  logic [NUM_LANES*MANT_W-1:0]   i_mant,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [ACC_W-1:0]              o_sum,
  output logic [EXP_W-1:0]              o_exp,
  output logic                          o_err,
  output logic [1:0]                    o_dbg_state
);

  // Handshakes: a transfer happens on an edge where valid and ready are both
  // high; valid, once raised, holds its payload stable until that edge.

  localparam logic [3:0] LAST_LANE = 4'(NUM_LANES - 1);

  state_e                       state_q, state_d;
  logic [3:0]                   cnt_q, cnt_d;
  logic signed [ACC_W-1:0]      acc_q, acc_d;
  logic                         err_q, err_d;
  logic [NUM_LANES-1:0]         skip_q, skip_d;
  logic [NUM_LANES-1:0]         sign_q, sign_d;
  logic [NUM_LANES*EXP_W-1:0]   exp_q, exp_d;
  logic [NUM_LANES*MANT_W-1:0]  mant_q, mant_d;
  logic [EXP_W-1:0]             max_exp_q, max_exp_d;
  logic                         valid_q, valid_d;
  logic [ACC_W-1:0]             sum_q, sum_d;
  logic [EXP_W-1:0]             oexp_q, oexp_d;
  logic                         oerr_q, oerr_d;

  logic [MANT_W-1:0]            lane_mant;
  logic [EXP_W-1:0]             lane_exp;
  logic                         lane_skip;
  logic                         lane_sign;
  logic signed [ACC_W-1:0]      lane_val;
  logic                         lane_over;
  logic signed [ACC_W-1:0]      acc_sum;
  logic                         err_sum;

  // Lane 0 lives in the most significant slice of every packed bus.
  always_comb begin
    lane_mant = '0;
    lane_exp  = '0;
    lane_skip = 1'b0;
    lane_sign = 1'b0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (cnt_q == 4'(l)) begin
        lane_mant = mant_q[(NUM_LANES-1-l)*MANT_W +: MANT_W];
        lane_exp  = exp_q[(NUM_LANES-1-l)*EXP_W +: EXP_W];
        lane_skip = skip_q[NUM_LANES-1-l];
        lane_sign = sign_q[NUM_LANES-1-l];
      end
    end
  end

  align_shift_lane #(
    .EXP_W  (EXP_W),
    .MANT_W (MANT_W),
    .GUARD  (GUARD),
    .ACC_W  (ACC_W)
  ) u_lane (
    .mant_i    (lane_mant),
    .exp_i     (lane_exp),
    .max_exp_i (max_exp_q),
    .skip_i    (lane_skip),
    .sign_i    (lane_sign),
    .aligned_o (lane_val),
    .over_o    (lane_over)
  );

  assign acc_sum = acc_q + lane_val;
  assign err_sum = err_q | lane_over;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    err_d     = err_q;
    skip_d    = skip_q;
    sign_d    = sign_q;
    exp_d     = exp_q;
    mant_d    = mant_q;
    max_exp_d = max_exp_q;
    valid_d   = valid_q;
    sum_d     = sum_q;
    oexp_d    = oexp_q;
    oerr_d    = oerr_q;
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          skip_d    = i_skip;
          sign_d    = i_sign;
          exp_d     = i_exp;
          mant_d    = i_mant;
          max_exp_d = i_max_exp;
          acc_d     = '0;
          cnt_d     = '0;
          err_d     = 1'b0;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d = acc_sum;
        err_d = err_sum;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_LANE) begin
          state_d = ST_HOLD;
          valid_d = 1'b1;
          sum_d   = acc_sum;
          oexp_d  = max_exp_q;
          oerr_d  = err_sum;
        end
      end
      ST_HOLD: begin
        if (i_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      err_q     <= 1'b0;
      skip_q    <= '0;
      sign_q    <= '0;
      exp_q     <= '0;
      mant_q    <= '0;
      max_exp_q <= '0;
      valid_q   <= 1'b0;
      sum_q     <= '0;
      oexp_q    <= '0;
      oerr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      err_q     <= err_d;
      skip_q    <= skip_d;
      sign_q    <= sign_d;
      exp_q     <= exp_d;
      mant_q    <= mant_d;
      max_exp_q <= max_exp_d;
      valid_q   <= valid_d;
      sum_q     <= sum_d;
      oexp_q    <= oexp_d;
      oerr_q    <= oerr_d;
    end
  end

  assign o_ready     = (state_q == ST_IDLE);
  assign o_valid     = valid_q;
  assign o_sum       = sum_q;
  assign o_exp       = oexp_q;
  assign o_err       = oerr_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_align_accum_serial.sv
// Directed bench for align_accum_serial: hand-computed sums for alignment,
// sign, shift limits, error lanes, backpressure and mid-transaction reset.
module tb_align_accum_serial;

  localparam int EXP_W  = 6;
  localparam int MANT_W = 12;
  localparam int ACC_W  = 20;

  logic                 i_clk = 1'b0;
  logic                 i_rst = 1'b1;
  logic                 i_valid = 1'b0;
  logic                 o_ready;
  logic [8:0]           i_skip = '0;
  logic [EXP_W-1:0]     i_max_exp = '0;
  logic [8:0]           i_sign = '0;
  logic [9*EXP_W-1:0]   i_exp = '0;
  logic [9*MANT_W-1:0]  i_mant = '0;
  logic                 o_valid;
  logic                 i_ready = 1'b0;
  logic [ACC_W-1:0]     o_sum;
  logic [EXP_W-1:0]     o_exp;
  logic                 o_err;
  logic [1:0]           o_dbg_state;

  int checks = 0;
  int errors = 0;
  logic [ACC_W-1:0] exp_q[$];

  align_accum_serial dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_skip      (i_skip),
    .i_max_exp   (i_max_exp),
    .i_sign      (i_sign),
    .i_exp       (i_exp),
    .i_mant      (i_mant),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_sum       (o_sum),
    .o_exp       (o_exp),
    .o_err       (o_err),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- clock ----------------
  always #5 i_clk = ~i_clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // ---------------- drivers ----------------
  task automatic load(input logic [8:0] skip, input logic [5:0] mx, input logic [8:0] sg,
                      input logic [53:0] ev, input logic [107:0] mv);
    i_skip    = skip;
    i_max_exp = mx;
    i_sign    = sg;
    i_exp     = ev;
    i_mant    = mv;
    i_valid   = 1'b1;
  endtask

  // Present the loaded bundle until an edge where o_ready was high.
  task automatic send(input string tag);
    logic rdy;
    bit   done;
    done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      rdy = o_ready;
      tick();
      if (rdy) done = 1'b1;
    end
    i_valid = 1'b0;
    if (!done) check({tag, "_accept_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_result(input string tag, output int cycles);
    cycles = 0;
    for (int n = 1; n <= 40 && cycles == 0; n++) begin
      tick();
      if (o_valid) cycles = n;
    end
    if (cycles == 0) check({tag, "_valid_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic check_result(input string tag, input logic [5:0] ex_exp, input logic ex_err);
    logic [ACC_W-1:0] es;
    es = exp_q.pop_front();
    check({tag, "_sum"},   32'(o_sum), 32'(es));
    check({tag, "_exp"},   32'(o_exp), 32'(ex_exp));
    check({tag, "_err"},   32'(o_err), 32'(ex_err));
    check({tag, "_ready"}, 32'(o_ready), 32'd0);
  endtask

  task automatic handshake(input string tag);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(o_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(o_ready), 32'd1);
  endtask

  task automatic run_txn(input string tag, input logic [8:0] skip, input logic [5:0] mx,
                         input logic [8:0] sg, input logic [53:0] ev, input logic [107:0] mv,
                         input logic [ACC_W-1:0] ex_sum, input logic ex_err);
    int cyc;
    exp_q.push_back(ex_sum);
    load(skip, mx, sg, ev, mv);
    send(tag);
    wait_result(tag, cyc);
    check({tag, "_latency"}, 32'(cyc), 32'd9);
    check_result(tag, mx, ex_err);
    handshake(tag);
  endtask

  function automatic logic [53:0] all_exp(input logic [5:0] e);
    return {9{e}};
  endfunction

  function automatic logic [107:0] all_mant(input logic [11:0] m);
    return {9{m}};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [53:0]  ev;
    logic [107:0] mv;
    logic [ACC_W-1:0] held_sum;
    int cyc;

    repeat (3) tick();
    i_rst = 1'b0;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_sum",   32'(o_sum), 32'd0);
    check("rst_exp",   32'(o_exp), 32'd0);
    check("rst_err",   32'(o_err), 32'd0);
    check("rst_state", 32'(o_dbg_state), 32'd0);

    // 1: nine full lanes at max exponent -> 9 * 0x4000
    run_txn("t1_full", 9'h000, 6'd10, 9'h000, all_exp(6'd10), all_mant(12'h800), 20'd147456, 1'b0);

    // 2: lane1 two below max -> 0x4000 + 0x1000, then lane1 negated
    ev = all_exp(6'd63);
    ev[53:48] = 6'd10;
    ev[47:42] = 6'd8;
    mv = all_mant(12'hFFF);
    mv[107:96] = 12'h800;
    mv[95:84]  = 12'h800;
    run_txn("t2_pos", 9'h07F, 6'd10, 9'h000, ev, mv, 20'd20480, 1'b0);
    run_txn("t2_neg", 9'h07F, 6'd10, 9'h080, ev, mv, 20'd12288, 1'b0);

    // 3: shift 14 keeps one bit, shift 15 clears the lane
    ev[53:48] = 6'd6;
    run_txn("t3_sh14", 9'h0FF, 6'd20, 9'h000, ev, mv, 20'd1, 1'b0);
    ev[53:48] = 6'd5;
    run_txn("t3_sh15", 9'h0FF, 6'd20, 9'h000, ev, mv, 20'd0, 1'b0);

    // 4: exponent above max on a live lane; skipped lanes carry exp 63 too
    ev[53:48] = 6'd12;
    mv[107:96] = 12'h001;
    run_txn("t4_err",  9'h0FF, 6'd10, 9'h000, ev, mv, 20'd8, 1'b1);
    run_txn("t4_skip", 9'h1FF, 6'd10, 9'h000, ev, mv, 20'd0, 1'b0);

    // 5: backpressure with a competing bundle waiting upstream
    exp_q.push_back(20'd147456);
    load(9'h000, 6'd10, 9'h000, all_exp(6'd10), all_mant(12'h800));
    send("t5_a");
    wait_result("t5_a", cyc);
    check("t5_a_latency", 32'(cyc), 32'd9);
    held_sum = o_sum;
    ev = all_exp(6'd63);
    ev[53:48] = 6'd10;
    ev[47:42] = 6'd8;
    mv = all_mant(12'h800);
    load(9'h07F, 6'd10, 9'h000, ev, mv);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t5_hold_valid", 32'(o_valid), 32'd1);
      check("t5_hold_sum",   32'(o_sum), 32'(held_sum));
      check("t5_hold_exp",   32'(o_exp), 32'd10);
      check("t5_hold_ready", 32'(o_ready), 32'd0);
    end
    check_result("t5_a", 6'd10, 1'b0);
    handshake("t5_a");
    tick();
    i_valid = 1'b0;
    check("t5_b_taken", 32'(o_ready), 32'd0);
    exp_q.push_back(20'd20480);
    wait_result("t5_b", cyc);
    check("t5_b_latency", 32'(cyc), 32'd9);
    check_result("t5_b", 6'd10, 1'b0);
    handshake("t5_b");

    // 6: reset during the fourth RUN cycle abandons the transaction
    load(9'h000, 6'd10, 9'h000, all_exp(6'd10), all_mant(12'h800));
    send("t6_abort");
    repeat (3) tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check("t6_rst_valid", 32'(o_valid), 32'd0);
    check("t6_rst_ready", 32'(o_ready), 32'd1);
    check("t6_rst_sum",   32'(o_sum), 32'd0);
    run_txn("t6_after", 9'h000, 6'd10, 9'h000, all_exp(6'd10), all_mant(12'h800), 20'd147456, 1'b0);

    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/align_accum_serial.md
Name: align_accum_serial

Overview:
- Stage directly downstream of the 9-input max-exponent determination in the MAC subsystem.
- Accepts one 9-lane bundle of product signs, exponents and significands, together with the shared maximum exponent.
- Right-aligns each non-skipped lane to that maximum exponent, applies its sign, and accumulates the lanes serially, one lane per cycle.
- Presents a signed fixed-point sum plus the common exponent to the normaliser through a valid/ready handshake.

Parameters:
- EXP_W, 6, exponent width per lane (FP16 exponent width + 1).
- MANT_W, 12, unsigned product significand width per lane.
- GUARD, 3, guard bits appended below the LSB before shifting.
- ACC_W, 20, signed accumulator width (MANT_W+GUARD+5; sized so 9 full-scale lanes cannot overflow).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  input bundle valid.
- o_ready  out  1  block can accept a bundle.
- i_skip  in  9  skip flags; bit 8 = lane 0 … bit 0 = lane 8.
- i_max_exp  in  EXP_W  maximum exponent from the upstream stage.
- i_sign  in  9  lane sign, 1 = negative; bit 8 = lane 0.
- i_exp  in  9*EXP_W  lane exponents; lane 0 in MSBs.
- i_mant  in  9*MANT_W  lane significands; lane 0 in MSBs.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts the result.
- o_sum  out  ACC_W  signed two's-complement aligned sum.
- o_exp  out  EXP_W  exponent of o_sum (the captured i_max_exp).
- o_err  out  1  some non-skipped lane had exp > max_exp in this transaction.

Behaviour:
- Clocking: one clock, i_clk. Reset i_rst is synchronous and active-high. On reset: state IDLE, lane counter 0, accumulator 0, o_valid 0, o_sum 0, o_exp 0, o_err 0. o_ready = (state==IDLE), so it reads 1 in the first cycle after reset.
- FSM states: IDLE, RUN, HOLD.
- IDLE:
  - On i_valid && o_ready at an edge, register all inputs, clear accumulator, counter and error flag, and go to RUN.
  - i_valid while not in IDLE is ignored; upstream holds the bundle.
- RUN: each edge processes lane cnt:
  - shamt = max_exp − exp[cnt] (unsigned).
  - aligned = ({mant, GUARD zeros}) >> shamt, zero-extended to ACC_W. Bits shifted out are discarded (truncation, no sticky).
  - shamt ≥ MANT_W+GUARD gives 0.
  - If exp > max_exp on a non-skipped lane: use shamt = 0 and set the error flag.
  - Skipped lane contributes 0 and never sets the error flag.
  - Negative sign subtracts aligned; positive adds.
  - cnt increments; after lane 8, go to HOLD.
- Latency and throughput:
  - Accept edge T; lanes are accumulated at edges T+1 … T+9.
  - At edge T+9: o_valid=1, o_sum=accumulator, o_exp=captured max_exp, o_err=flag.
  - One bundle per 11 cycles minimum.
- HOLD:
  - o_valid, o_sum, o_exp and o_err stay stable until i_ready is seen high at an edge.
  - Then o_valid=0 and state returns to IDLE.
  - o_ready stays 0 throughout HOLD; there is no same-cycle re-accept.
- All lanes skipped: o_sum=0, o_exp=max_exp, o_err=0.
- Reset mid-RUN or mid-HOLD: the transaction is abandoned, with no partial output.
- The accumulator never overflows with the default widths; no saturation logic.

Decomposition:
- Shared MAC package holds:
  - NUM_LANES=9
  - FP16_EXP_W=5
  - the FSM state encoding (IDLE/RUN/HOLD)
  - default MANT_W/GUARD/ACC_W constants
- One natural combinational sub-module: align_shift_lane.
  - Inputs: mant, exp, max_exp, skip, sign.
  - Outputs: signed aligned value and the exp>max_exp flag.
  - Instantiated once and fed by a lane mux driven by cnt.

Test Plan:
1. All 9 lanes: mant=0x800, exp=10, sign=0; max_exp=10; skip=0 → o_valid exactly 9 cycles after accept, o_sum=147456 (0x24000), o_exp=10, o_err=0.
2. Lane0 {0x800, exp10}, lane1 {0x800, exp8}, others skipped (skip=0x07F), max_exp=10 → o_sum=16384+4096=20480. Repeat with lane1 sign=1 → o_sum=12288.
3. Shift boundaries, lane0 only, mant=0x800, max_exp=20: exp=6 (shamt 14) → o_sum=1; exp=5 (shamt 15) → o_sum=0.
4. Error path: lane0 exp=12, max_exp=10, mant=0x001 → o_sum=8, o_err=1. Same bundle with skip[8]=1 → o_sum=0, o_err=0.
5. Backpressure: i_ready held 0 for 5 cycles after o_valid → o_sum, o_exp and o_valid stable; o_ready=0; a new i_valid bundle is not accepted until the cycle after the output handshake.
6. Reset: assert i_rst during RUN cycle 4 → next cycle o_valid=0, o_ready=1; then scenario 1 bundle → o_sum=147456, unaffected by the aborted transaction.
